// File: rtl/intersection_pkg.sv
// intersection_pkg: state encoding, per-state lamp vectors and default phase durations
package intersection_pkg;
  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALLRED_1 = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    PED_WALK = 3'd5,
    ALLRED_2 = 3'd6
  } state_t;
  typedef struct packed {
    logic main_g;
    logic main_y;
    logic main_r;
    logic side_g;
    logic side_y;
    logic side_r;
    logic walk;
  } lamps_t;
  localparam lamps_t L_MAIN_G  = 7'b100_001_0;
  localparam lamps_t L_MAIN_Y  = 7'b010_001_0;
  localparam lamps_t L_SIDE_G  = 7'b001_100_0;
  localparam lamps_t L_SIDE_Y  = 7'b001_010_0;
  localparam lamps_t L_WALK    = 7'b001_001_1;
  localparam lamps_t L_ALL_RED = 7'b001_001_0;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_GREEN_MIN    = 20;
  localparam int DEF_YELLOW_T     = 4;
  localparam int DEF_ALLRED_T     = 2;
  localparam int DEF_SIDE_GREEN_T = 10;
  localparam int DEF_WALK_T       = 8;
  function automatic lamps_t lamps_of(state_t s);
    case (s)
      MAIN_G:   return L_MAIN_G;
      MAIN_Y:   return L_MAIN_Y;
      SIDE_G:   return L_SIDE_G;
      SIDE_Y:   return L_SIDE_Y;
      PED_WALK: return L_WALK;
      default:  return L_ALL_RED;
    endcase
  endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: down-counter loaded with duration-1, advancing on tick, done on a tick at zero
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_done
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge i_clk)
    r_cnt <= i_load ? i_load_val : (i_tick && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  assign o_done = i_tick && r_cnt == '0;
endmodule

// File: rtl/intersection_controller.sv
// intersection_controller: main/side/pedestrian signal sequencer with round-robin request service
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int GREEN_MIN    = DEF_GREEN_MIN,
  parameter int YELLOW_T     = DEF_YELLOW_T,
  parameter int ALLRED_T     = DEF_ALLRED_T,
  parameter int SIDE_GREEN_T = DEF_SIDE_GREEN_T,
  parameter int WALK_T       = DEF_WALK_T
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_side_req,
  input  logic       i_ped_btn,
  output logic       o_main_g,
  output logic       o_main_y,
  output logic       o_main_r,
  output logic       o_side_g,
  output logic       o_side_y,
  output logic       o_side_r,
  output logic       o_walk,
  output logic       o_ped_ack,
  output logic [2:0] o_state
);
  state_t           r_state, w_next;
  lamps_t           r_lamps;
  logic             r_side_pend, r_ped_pend, r_last_ped, r_green_exp;
  logic             w_done, w_load, w_serve_side, w_enter_side, w_enter_ped;
  logic [CNT_W-1:0] w_load_val;
  function automatic logic [CNT_W-1:0] dur_m1(state_t s);
    case (s)
      MAIN_G:   return CNT_W'(GREEN_MIN - 1);
      MAIN_Y:   return CNT_W'(YELLOW_T - 1);
      SIDE_Y:   return CNT_W'(YELLOW_T - 1);
      SIDE_G:   return CNT_W'(SIDE_GREEN_T - 1);
      PED_WALK: return CNT_W'(WALK_T - 1);
      default:  return CNT_W'(ALLRED_T - 1);
    endcase
  endfunction
  assign w_serve_side = r_side_pend && (!r_ped_pend || r_last_ped);
  always_comb begin
    w_next = r_state;
    case (r_state)
      MAIN_G:   if ((w_done || r_green_exp) && (r_side_pend || r_ped_pend)) w_next = MAIN_Y;
      MAIN_Y:   if (w_done) w_next = ALLRED_1;
      ALLRED_1: if (w_done) w_next = w_serve_side ? SIDE_G : r_ped_pend ? PED_WALK : ALLRED_2;
      SIDE_G:   if (w_done) w_next = SIDE_Y;
      SIDE_Y:   if (w_done) w_next = ALLRED_2;
      PED_WALK: if (w_done) w_next = ALLRED_2;
      ALLRED_2: if (w_done) w_next = MAIN_G;
      default:  w_next = ALLRED_2;
    endcase
  end
  assign w_load       = !i_reset || w_next != r_state;
  assign w_load_val   = !i_reset ? dur_m1(MAIN_G) : dur_m1(w_next);
  assign w_enter_side = w_next == SIDE_G && r_state != SIDE_G;
  assign w_enter_ped  = w_next == PED_WALK && r_state != PED_WALK;
  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_tick     (i_tick),
    .o_done     (w_done)
  );
  // Lamps are registered from the next state so they always match r_state.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= MAIN_G;
      r_lamps     <= L_MAIN_G;
      r_side_pend <= 1'b0;
      r_ped_pend  <= 1'b0;
      r_last_ped  <= 1'b1;
      r_green_exp <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_lamps     <= lamps_of(w_next);
      r_side_pend <= !w_enter_side && (r_side_pend || (i_side_req && r_state != SIDE_G && r_state != SIDE_Y));
      r_ped_pend  <= !w_enter_ped && (r_ped_pend || (i_ped_btn && r_state != PED_WALK));
      if (w_enter_side || w_enter_ped) r_last_ped <= w_enter_ped;
      r_green_exp <= r_state == MAIN_G && w_next == MAIN_G && (r_green_exp || w_done);
    end
  end
  assign {o_main_g, o_main_y, o_main_r, o_side_g, o_side_y, o_side_r, o_walk} = r_lamps;
  assign o_ped_ack = r_ped_pend;
  assign o_state   = r_state;
endmodule

// File: tb/tb_intersection_controller.sv
// tb_intersection_controller: directed table-driven and sequence checks of the intersection sequencer
module tb_intersection_controller;
  localparam int MG = 0, MY = 1, AR1 = 2, SG = 3, SY = 4, PW = 5, AR2 = 6;
  logic clk = 0, reset = 0, tick = 1, side_req = 0, ped_btn = 0;
  logic o_main_g, o_main_y, o_main_r, o_side_g, o_side_y, o_side_r, o_walk, o_ped_ack;
  logic [2:0] o_state;
  logic [6:0] lamps;
  logic inv_on = 0;
  int n_pass = 0, n_total = 0;
  typedef struct {
    logic rst;
    logic side;
    logic ped;
    int   st;
    logic ack;
  } vec_t;
  vec_t vecs[$];
  intersection_controller #(
    .CNT_W(4), .GREEN_MIN(4), .YELLOW_T(2), .ALLRED_T(1), .SIDE_GREEN_T(3), .WALK_T(3)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_side_req(side_req), .i_ped_btn(ped_btn),
    .o_main_g(o_main_g), .o_main_y(o_main_y), .o_main_r(o_main_r),
    .o_side_g(o_side_g), .o_side_y(o_side_y), .o_side_r(o_side_r),
    .o_walk(o_walk), .o_ped_ack(o_ped_ack), .o_state(o_state)
  );
  assign lamps = {o_main_g, o_main_y, o_main_r, o_side_g, o_side_y, o_side_r, o_walk};
  always #5 clk = ~clk;
  function automatic logic [6:0] lamp_of(int s);
    case (s)
      MG:      return 7'b1000010;
      MY:      return 7'b0100010;
      SG:      return 7'b0011000;
      SY:      return 7'b0010100;
      PW:      return 7'b0010011;
      default: return 7'b0010010;
    endcase
  endfunction
  function automatic int exp_phase(int p);
    return p < 4 ? MG : p < 6 ? MY : p == 6 ? AR1 : p < 10 ? SG : p < 12 ? SY : AR2;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic chk_state(input string tag, input int st);
    chk({tag, " state"}, int'(o_state), st);
    chk({tag, " lamps"}, int'(lamps), int'(lamp_of(st)));
  endtask
  task automatic cyc(input logic rst, input logic s, input logic p);
    reset = rst;
    side_req = s;
    ped_btn = p;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic rst, input logic s, input logic p, input int st, input logic ack);
    vec_t v;
    v.rst = rst; v.side = s; v.ped = p; v.st = st; v.ack = ack;
    vecs.push_back(v);
  endtask
  always @(negedge clk)
    if (inv_on)
      chk("invariant", int'($countones({o_main_g, o_main_y, o_main_r}) == 1 &&
                            $countones({o_side_g, o_side_y, o_side_r}) == 1 &&
                            (o_main_r || o_side_r) && (!o_walk || (o_main_r && o_side_r))), 1);
  initial begin
    int cnt[7];
    bit seen;
    add(0,0,0,MG,0); add(0,0,0,MG,0); add(1,0,0,MG,0); add(1,0,1,MG,1); add(1,0,0,MG,1);
    add(1,0,0,MY,1); add(1,0,0,MY,1); add(1,0,0,AR1,1); add(1,0,0,PW,0); add(1,0,0,PW,0);
    add(1,0,0,PW,0); add(1,0,0,AR2,0); add(1,0,0,MG,0); add(1,0,0,MG,0);
    add(0,0,0,MG,0); add(1,1,1,MG,1); add(1,0,0,MG,1); add(1,0,0,MG,1); add(1,0,0,MY,1);
    add(1,0,0,MY,1); add(1,0,0,AR1,1); add(1,0,0,SG,1); add(1,0,0,SG,1); add(1,0,0,SG,1);
    add(1,0,0,SY,1); add(1,0,0,SY,1); add(1,0,0,AR2,1); add(1,0,0,MG,1); add(1,0,0,MG,1);
    add(1,0,0,MG,1); add(1,0,0,MG,1); add(1,0,0,MY,1); add(1,0,0,MY,1); add(1,0,0,AR1,1);
    add(1,0,0,PW,0); add(1,0,0,PW,0); add(1,0,0,PW,0); add(1,0,0,AR2,0); add(1,0,0,MG,0);
    @(posedge clk);
    #1;
    inv_on = 1;
    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].side, vecs[i].ped);
      chk_state($sformatf("vec%0d", i), vecs[i].st);
      chk($sformatf("vec%0d ack", i), int'(o_ped_ack), int'(vecs[i].ack));
    end
    cyc(0,0,0); cyc(0,0,0);
    for (int k = 0; k < 50; k++) begin
      cyc(1,0,0);
      chk_state($sformatf("idle%0d", k), MG);
    end
    cyc(0,0,0); cyc(0,0,0);
    for (int k = 0; k < 39; k++) begin
      cyc(1,1,0);
      chk_state($sformatf("side_held%0d", k), exp_phase((k + 1) % 13));
    end
    cyc(0,0,0); cyc(0,0,0); cyc(1,1,0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(1, 0, o_state == 3'(SG));
      seen = o_state == 3'(SY);
    end
    chk("reach SIDE_Y", int'(seen), 1);
    chk("ack before reset", int'(o_ped_ack), 1);
    cyc(0,1,1);
    chk_state("reset in SIDE_Y", MG);
    chk("reset ack", int'(o_ped_ack), 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1,0,0);
      chk_state($sformatf("after_abort%0d", k), MG);
    end
    cyc(0,0,0); cyc(0,0,0);
    foreach (cnt[i]) cnt[i] = 0;
    for (int c = 0; c < 80; c++) begin
      tick = (c % 3 == 2);
      cyc(1, 0, c == 1);
      cnt[o_state]++;
    end
    tick = 1;
    chk("slow MAIN_Y clks", cnt[MY], 6);
    chk("slow ALLRED_1 clks", cnt[AR1], 3);
    chk("slow PED_WALK clks", cnt[PW], 9);
    chk("slow ALLRED_2 clks", cnt[AR2], 3);
    chk("slow SIDE_G clks", cnt[SG], 0);
    chk_state("slow end", MG);
    inv_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
